serial_subtractor: RTL and testbench

//  Bit-serial subtractor computing out_diff = in_a - in_b, one bit per clock, LSB first.

---
 rtl/arith_pkg.sv | 13 +
 rtl/serial_subtractor_fullsubtractor.sv | 15 +
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial subtractor FSM states and limits.
package arith_pkg;

  typedef enum logic [1:0] {SUB_IDLE, SUB_RUN, SUB_DONE} sub_state_t;

  localparam int unsigned SUB_MIN_BITS = 2;

  // Width of a counter that must reach the value n without wrapping.
  function automatic int unsigned sub_cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full-subtractor cell: diff = a - b - borrow_in, with borrow out.
module fullsubtractor (
  input  logic in_a,
  input  logic in_b,
  input  logic in_borrow,
  output logic out_diff,
  output logic out_borrow
);

  always_comb begin
    out_diff   = in_a ^ in_b ^ in_borrow;
    out_borrow = (~in_a & in_b) | (~(in_a ^ in_b) & in_borrow);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor (LSB first), one full-subtractor cell, BITS+2 cycles per op.
// Optional signed-overflow flag enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_start,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  output logic            out_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_diff,
  output logic            out_borrow,
  output logic            out_ovf
);

  localparam int unsigned CW = sub_cnt_width(BITS);

  sub_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [BITS-1:0] a_sr, b_sr, res_sr;
  logic [BITS-1:0] diff_q;
  logic            bin_q;
  logic            borrow_q;
  logic            bit_d, bit_bo;
  logic            accept, last_bit;

  fullsubtractor u_fs (
    .in_a      (a_sr[0]),
    .in_b      (b_sr[0]),
    .in_borrow (bin_q),
    .out_diff  (bit_d),
    .out_borrow(bit_bo)
  );

  assign accept   = (state_q == SUB_IDLE) && in_start;
  assign last_bit = (state_q == SUB_RUN) && (cnt_q == CW'(BITS - 1));

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= SUB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    out_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      SUB_IDLE: begin
        out_ready = 1'b1;
        if (in_start) state_d = SUB_RUN;
      end
      SUB_RUN: begin
        if (last_bit) state_d = SUB_DONE;
      end
      SUB_DONE: begin
        out_valid = 1'b1;
        state_d   = SUB_IDLE;
      end
      default: state_d = SUB_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bin_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      a_sr   <= in_a;
      b_sr   <= in_b;
      res_sr <= '0;
      bin_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (state_q == SUB_RUN) begin
      a_sr   <= {1'b0, a_sr[BITS-1:1]};
      b_sr   <= {1'b0, b_sr[BITS-1:1]};
      res_sr <= {bit_d, res_sr[BITS-1:1]};
      bin_q  <= bit_bo;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // Results are captured on the final bit edge so they stay stable until the next op completes.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (last_bit) begin
      diff_q   <= {bit_d, res_sr[BITS-1:1]};
      borrow_q <= bit_bo;
    end
  end

  assign out_diff   = diff_q;
  assign out_borrow = borrow_q;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic ovf_q;

  // On the last bit the shift regs present the original operand MSBs at bit 0.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)        ovf_q <= 1'b0;
    else if (last_bit) ovf_q <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ bit_d);
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (BITS=16): directed vectors plus a random soak.
module tb_serial_subtractor;

  localparam int unsigned BITS = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [BITS-1:0] a = '0, b = '0;
  logic            ready, valid, borrow, ovf;
  logic [BITS-1:0] diff;

  typedef struct {
    logic [BITS-1:0] d;
    logic            bo;
    logic            ov;
  } exp_t;

  exp_t sbq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  serial_subtractor #(.BITS(BITS)) dut (
    .in_clk    (clk),
    .in_rst    (rst),
    .in_start  (start),
    .in_a      (a),
    .in_b      (b),
    .out_ready (ready),
    .out_valid (valid),
    .out_diff  (diff),
    .out_borrow(borrow),
    .out_ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [BITS-1:0] x, input logic [BITS-1:0] y);
    exp_t e;
    e.d  = x - y;
    e.bo = (x < y);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    e.ov = (x[BITS-1] ^ y[BITS-1]) & (x[BITS-1] ^ e.d[BITS-1]);
`else
    e.ov = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: every valid pulse pops one expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got valid with empty scoreboard diff=%h", diff);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("borrow", 32'(borrow), 32'(e.bo));
        check("ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  task automatic run_op(input logic [BITS-1:0] x, input logic [BITS-1:0] y, input bit poke);
    int unsigned n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", 32'(ready), 32'd1);
    a = x;
    b = y;
    start = 1'b1;
    sbq.push_back(model(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = BITS'($urandom);
    b = BITS'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (poke && n == 5) begin
        check("ready_in_run", 32'(ready), 32'd0);
        a = 16'h0F0F;
        b = 16'h7777;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end while (!valid && n < 40);
    start = 1'b0;
    check("latency", n, BITS + 1);
    @(negedge clk);
    check("ready_after_valid", 32'(ready), 32'd1);
    check("valid_one_cycle", 32'(valid), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h2345, 16'h1234, 1'b0);
    run_op(16'h1234, 16'h2345, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    run_op(16'hABCD, 16'hABCD, 1'b0);
    run_op(16'h5555, 16'h1111, 1'b1);

    // Reset while bit 7 is being processed; no expectation is queued.
    a = 16'hAAAA;
    b = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'd5, 16'd3, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op(BITS'($urandom), BITS'($urandom), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
